// File: rtl/arith_pkg.sv
// arith_pkg: shared mode constants and pipeline sizing helpers for the add/sub unit
package arith_pkg;
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;
    function automatic int nstages(input int width, input int chunk);
        return width / chunk;
    endfunction
    function automatic bit cfg_ok(input int width, input int chunk);
        return chunk >= 1 && chunk <= width && (width % chunk) == 0;
    endfunction
endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit adder slice
//   a_i, b_i : slice operands (b already conditionally inverted)
//   c_i      : carry into the slice
//   s_o      : slice sum
//   c_o      : carry out of the slice MSB
//   cm_o     : carry into the slice MSB
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o,
    output logic             cm_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the sum
    assign cm_o = s_o[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract, one CHUNK-bit slice per pipeline stage
//   in_valid/in_ready   : operand handshake (a, b, c_in, sub)
//   out_valid/out_ready : result handshake (sum, c_out, ovf)
//   latency NSTAGES cycles, one beat per cycle, whole pipe stalls on back-pressure
module pipelined_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NSTAGES = nstages(WIDTH, CHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    logic             adv;
    logic             v_q [NSTAGES];
    logic [WIDTH-1:0] a_q [NSTAGES];
    logic [WIDTH-1:0] b_q [NSTAGES];
    logic [WIDTH-1:0] s_q [NSTAGES];
    logic             c_q [NSTAGES];
    logic             m_q [NSTAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_st
        logic             v_d, c_prev, c_d, m_d;
        logic [WIDTH-1:0] a_d, b_d, s_prev, s_d;
        logic [CHUNK-1:0] sl;
        if (k == 0) begin : g_first
            assign v_d    = in_valid;
            assign a_d    = a;
            assign b_d    = (sub == SUB) ? ~b : b;
            assign c_prev = c_in ^ sub;
            assign s_prev = '0;
        end else begin : g_next
            assign v_d    = v_q[k-1];
            assign a_d    = a_q[k-1];
            assign b_d    = b_q[k-1];
            assign c_prev = c_q[k-1];
            assign s_prev = s_q[k-1];
        end
        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a_i  (a_d[k*CHUNK +: CHUNK]),
            .b_i  (b_d[k*CHUNK +: CHUNK]),
            .c_i  (c_prev),
            .s_o  (sl),
            .c_o  (c_d),
            .cm_o (m_d)
        );
        always_comb begin
            s_d = s_prev;
            s_d[k*CHUNK +: CHUNK] = sl;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                m_q[k] <= 1'b0;
            end else if (adv) begin
                v_q[k] <= v_d;
                a_q[k] <= a_d;
                b_q[k] <= b_d;
                s_q[k] <= s_d;
                c_q[k] <= c_d;
                m_q[k] <= m_d;
            end
        end
    end

    assign out_valid = v_q[NSTAGES-1];
    assign sum       = s_q[NSTAGES-1];
    assign c_out     = c_q[NSTAGES-1];
    // final slice MSB is bit WIDTH-1: carry in vs carry out gives signed overflow
    assign ovf       = c_q[NSTAGES-1] ^ m_q[NSTAGES-1];
endmodule
